// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter that shares one RAM port among CPUS cores (I-read, D-read, D-write).
// Optional ARB_STARVE_EN adds per-core age counters that force service of long-waiting cores.
module ram_port_arbiter #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic [CPUS-1:0]            iREN,
  input  logic [CPUS-1:0]            dREN,
  input  logic [CPUS-1:0]            dWEN,
  input  logic [CPUS*WORD_W-1:0]     iaddr,
  input  logic [CPUS*WORD_W-1:0]     daddr,
  input  logic [CPUS*WORD_W-1:0]     dstore,
  output logic [CPUS-1:0]            iwait,
  output logic [CPUS-1:0]            dwait,
  output logic [CPUS*WORD_W-1:0]     iload,
  output logic [CPUS*WORD_W-1:0]     dload,
  output logic                       ramREN,
  output logic                       ramWEN,
  output logic [WORD_W-1:0]          ramaddr,
  output logic [WORD_W-1:0]          ramstore,
  input  logic [WORD_W-1:0]          ramload,
  input  logic [1:0]                 ramstate,
  output logic                       gnt_valid,
  output logic [$clog2(CPUS)-1:0]    gnt_id
);

  localparam int IDW = $clog2(CPUS);
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic {IDLE, GRANT} state_t;
  typedef enum logic [1:0] {REQ_I, REQ_DR, REQ_DW} req_t;

  state_t         state, state_n;
  req_t           gnt_type, win_type;
  logic [IDW-1:0] rr_ptr, rr_ptr_n, win_id;
  logic [CPUS-1:0] pend;
  logic           win_found, cur_req, complete;
  int             idx;

`ifdef ARB_STARVE_EN
  logic [3:0] age [CPUS];
`endif

  assign pend      = iREN | dREN | dWEN;
  assign gnt_valid = (state == GRANT);
  assign iload     = {CPUS{ramload}};
  assign dload     = {CPUS{ramload}};

  // First pending core at or after rr_ptr; a saturated age counter overrides it.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 0; k < CPUS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= CPUS) idx = idx - CPUS;
      if (!win_found && pend[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
`ifdef ARB_STARVE_EN
    for (int c = CPUS - 1; c >= 0; c--) begin
      if (pend[c] && age[c] == 4'hF) begin
        win_found = 1'b1;
        win_id    = IDW'(c);
      end
    end
`endif
    if (dWEN[win_id])      win_type = REQ_DW;
    else if (dREN[win_id]) win_type = REQ_DR;
    else                   win_type = REQ_I;
  end

  always_comb begin
    case (gnt_type)
      REQ_I:   cur_req = iREN[gnt_id];
      REQ_DR:  cur_req = dREN[gnt_id];
      default: cur_req = dWEN[gnt_id];
    endcase
  end

  always_comb begin
    state_n  = state;
    rr_ptr_n = rr_ptr;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    complete = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) state_n = GRANT;
      end
      default: begin
        // Winner withdrew its request: abandon the access without advancing rr_ptr.
        if (!cur_req) begin
          state_n = IDLE;
        end else begin
          ramREN   = (gnt_type != REQ_DW);
          ramWEN   = (gnt_type == REQ_DW);
          ramaddr  = (gnt_type == REQ_I) ? iaddr[gnt_id*WORD_W +: WORD_W]
                                         : daddr[gnt_id*WORD_W +: WORD_W];
          ramstore = dstore[gnt_id*WORD_W +: WORD_W];
          if (ramstate == RAM_ACCESS) begin
            complete = 1'b1;
            state_n  = IDLE;
            rr_ptr_n = (gnt_id == IDW'(CPUS - 1)) ? '0 : gnt_id + 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    iwait = '0;
    dwait = '0;
    for (int c = 0; c < CPUS; c++) begin
      iwait[c] = iREN[c] & ~(complete && gnt_type == REQ_I && gnt_id == IDW'(c));
      dwait[c] = (dREN[c] | dWEN[c]) & ~(complete && gnt_type != REQ_I && gnt_id == IDW'(c));
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gnt_id   <= '0;
      gnt_type <= REQ_I;
    end else begin
      state  <= state_n;
      rr_ptr <= rr_ptr_n;
      if (state == IDLE && win_found) begin
        gnt_id   <= win_id;
        gnt_type <= win_type;
      end
    end
  end

`ifdef ARB_STARVE_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int c = 0; c < CPUS; c++) age[c] <= '0;
    end else begin
      for (int c = 0; c < CPUS; c++) begin
        if (state == IDLE && win_found && win_id == IDW'(c))
          age[c] <= '0;
        else if (pend[c] && !(state == GRANT && gnt_id == IDW'(c)) && age[c] != 4'hF)
          age[c] <= age[c] + 4'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: a RAM responder drives ramstate, completions are
// popped from an expected-grant queue. Build with ARB_STARVE_EN to check the starvation override.
module tb_ram_port_arbiter;
  localparam int CPUS = 2;
  localparam int W    = 32;
  localparam logic [1:0] R_FREE = 2'd0, R_BUSY = 2'd1, R_ACC = 2'd2, R_ERR = 2'd3;

  logic                CLK, nRST;
  logic [CPUS-1:0]     iREN, dREN, dWEN, iwait, dwait;
  logic [CPUS*W-1:0]   iaddr, daddr, dstore, iload, dload;
  logic                ramREN, ramWEN, gnt_valid;
  logic [W-1:0]        ramaddr, ramstore, ramload;
  logic [1:0]          ramstate;
  logic [$clog2(CPUS)-1:0] gnt_id;

  typedef struct {
    int          id;
    bit          isI;
    bit          ren;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] store;
  } exp_t;

  exp_t sbq[$];
  int   compCycle[$];
  int   checks = 0, fails = 0;
  int   compCount = 0, cycle = 0, busyCnt = 0, latency = 1;
  bit   holdBusy = 0, errMode = 0;

  ram_port_arbiter #(.CPUS(CPUS), .WORD_W(W)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait),
    .iload(iload), .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .gnt_valid(gnt_valid), .gnt_id(gnt_id)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // RAM responder, then completion monitor that pops the scoreboard.
  always @(negedge CLK) begin
    cycle++;
    if (gnt_valid && (ramREN || ramWEN)) begin
      busyCnt++;
      if (holdBusy)               ramstate = R_BUSY;
      else if (busyCnt >= latency) ramstate = R_ACC;
      else                        ramstate = errMode ? R_ERR : R_BUSY;
    end else begin
      busyCnt  = 0;
      ramstate = R_FREE;
    end
    #1;
    if (gnt_valid && ramstate == R_ACC && (ramREN || ramWEN)) begin
      exp_t e;
      compCount++;
      compCycle.push_back(cycle);
      if (sbq.size() == 0) begin
        checkOutput("sb_unexpected", 1, 0);
      end else begin
        e = sbq.pop_front();
        checkOutput("comp_id", gnt_id, e.id);
        checkOutput("comp_ren", ramREN, e.ren);
        checkOutput("comp_wen", ramWEN, e.wen);
        checkOutput("comp_addr", ramaddr, e.addr);
        checkOutput("comp_store", ramstore, e.store);
        if (e.isI) checkOutput("comp_iwait", iwait[e.id], 0);
        else       checkOutput("comp_dwait", dwait[e.id], 0);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input int c, input bit i, input bit dr, input bit dw);
    iREN[c] = i;
    dREN[c] = dr;
    dWEN[c] = dw;
  endtask

  task automatic setCore(input int c, input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] ds);
    iaddr[c*W +: W]  = ia;
    daddr[c*W +: W]  = da;
    dstore[c*W +: W] = ds;
  endtask

  task automatic pushExp(input int id, input bit isI, input bit wen);
    exp_t e;
    e.id    = id;
    e.isI   = isI;
    e.ren   = !wen;
    e.wen   = wen;
    e.addr  = isI ? iaddr[id*W +: W] : daddr[id*W +: W];
    e.store = dstore[id*W +: W];
    sbq.push_back(e);
  endtask

  task automatic applyReset();
    nRST = 1'b0;
    iREN = '0; dREN = '0; dWEN = '0;
    holdBusy = 0; errMode = 0; latency = 1;
    for (int c = 0; c < CPUS; c++)
      setCore(c, 32'h1000 + c * 32'h10, 32'h2000 + c * 32'h10, 32'hA000_0000 + c);
    tick();
    nRST = 1'b1;
    tick();
  endtask

  task automatic waitDone(input string tag, input int n, input int budget);
    int k = 0;
    while (compCount < n && k < budget) begin
      tick();
      k++;
    end
    checkOutput(tag, compCount >= n, 1);
  endtask

  task automatic waitGrant(input string tag, input int budget);
    int k = 0;
    while (!gnt_valid && k < budget) begin
      tick();
      k++;
    end
    checkOutput(tag, gnt_valid, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base, expId;
    ramload = '0;
    applyReset();

    // Reset state and combinational paths
    checkOutput("rst_ramREN", ramREN, 0);
    checkOutput("rst_ramWEN", ramWEN, 0);
    checkOutput("rst_gnt_valid", gnt_valid, 0);
    checkOutput("rst_gnt_id", gnt_id, 0);
    checkOutput("rst_ramaddr", ramaddr, 0);
    checkOutput("rst_iwait", iwait, 0);
    checkOutput("rst_dwait", dwait, 0);
    ramload = 32'hCAFE_0001;
    #1;
    checkOutput("iload_bcast", iload, {2{32'hCAFE_0001}});
    checkOutput("dload_bcast", dload, {2{32'hCAFE_0001}});
    applyStimulus(1, 1, 0, 0);
    #1;
    checkOutput("raw_iwait", iwait, 2'b10);
    applyStimulus(1, 0, 0, 0);
    tick();

    // Single instruction read, ACCESS two cycles into the grant
    base = compCount;
    latency = 2;
    setCore(0, 32'h100, 32'h2000, 32'hA000_0000);
    applyStimulus(0, 1, 0, 0);
    pushExp(0, 1, 0);
    waitGrant("t2_grant", 5);
    @(negedge CLK); #2;
    checkOutput("t2_iwait_busy", iwait[0], 1);
    checkOutput("t2_ramREN", ramREN, 1);
    checkOutput("t2_ramaddr", ramaddr, 32'h100);
    waitDone("t2_done", base + 1, 10);
    applyStimulus(0, 0, 0, 0);
    // rr_ptr now 1: core1 must win a simultaneous request
    pushExp(1, 1, 0);
    pushExp(0, 1, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    waitDone("t2_rr1", base + 2, 10);
    applyStimulus(1, 0, 0, 0);
    waitDone("t2_rr0", base + 3, 10);
    applyStimulus(0, 0, 0, 0);

    // Continuous D-reads from both cores alternate with 2-cycle spacing
    applyReset();
    base = compCount;
    compCycle.delete();
    for (int r = 0; r < 2; r++) begin
      pushExp(0, 0, 0);
      pushExp(1, 0, 0);
    end
    applyStimulus(0, 0, 1, 0);
    applyStimulus(1, 0, 1, 0);
    waitDone("t3_done", base + 4, 30);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    for (int k = 1; k < 4; k++)
      checkOutput("t3_spacing", compCycle[k] - compCycle[k-1], 2);

    // dREN+dWEN together is a write
    applyReset();
    base = compCount;
    setCore(1, 32'h1010, 32'h40, 32'hDEAD_BEEF);
    applyStimulus(1, 0, 1, 1);
    pushExp(1, 0, 1);
    waitDone("t4_done", base + 1, 10);
    applyStimulus(1, 0, 0, 0);

    // Abort: winner drops its request before ACCESS
    applyReset();
    base = compCount;
    holdBusy = 1;
    applyStimulus(0, 0, 1, 0);
    waitGrant("t5_grant", 5);
    applyStimulus(0, 0, 0, 0);
    @(negedge CLK); #2;
    checkOutput("t5_abort_ren", ramREN, 0);
    checkOutput("t5_abort_dwait", dwait[0], 0);
    tick();
    checkOutput("t5_idle", gnt_valid, 0);
    checkOutput("t5_no_comp", compCount, base);
    holdBusy = 0;
    pushExp(0, 0, 0);
    pushExp(1, 0, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(1, 0, 1, 0);
    waitDone("t5_rr_kept", base + 2, 20);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);

    // ERROR for three cycles then ACCESS: outputs held, one completion
    applyReset();
    base = compCount;
    errMode = 1;
    latency = 4;
    setCore(0, 32'h200, 32'h2000, 32'hA000_0000);
    applyStimulus(0, 1, 0, 0);
    pushExp(0, 1, 0);
    waitGrant("t6_grant", 5);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK); #2;
      checkOutput("t6_hold_ren", ramREN, 1);
      checkOutput("t6_hold_addr", ramaddr, 32'h200);
      checkOutput("t6_hold_iwait", iwait[0], 1);
    end
    waitDone("t6_done", base + 1, 10);
    applyStimulus(0, 0, 0, 0);
    repeat (3) tick();
    checkOutput("t6_single", compCount, base + 1);

    // Asynchronous reset in the middle of a grant
    applyReset();
    holdBusy = 1;
    setCore(0, 32'h300, 32'h2000, 32'hA000_0000);
    applyStimulus(0, 1, 0, 0);
    waitGrant("t7_grant", 5);
    #2;
    nRST = 1'b0;
    #1;
    checkOutput("t7_rst_valid", gnt_valid, 0);
    checkOutput("t7_rst_ren", ramREN, 0);
    checkOutput("t7_rst_addr", ramaddr, 0);
    checkOutput("t7_rst_iwait", iwait[0], 1);
    applyStimulus(0, 0, 0, 0);

    // Starvation: core1 ages during a stalled grant, then core0 aborts and re-requests
    applyReset();
    holdBusy = 1;
    applyStimulus(0, 0, 1, 0);
    waitGrant("t8_grant", 5);
    applyStimulus(1, 0, 1, 0);
    repeat (17) tick();
    applyStimulus(0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 1, 0);
    tick();
`ifdef ARB_STARVE_EN
    expId = 1;
`else
    expId = 0;
`endif
    checkOutput("t8_valid", gnt_valid, 1);
    checkOutput("t8_winner", gnt_id, expId);
    applyReset();

    checkOutput("sb_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
